// File: rtl/mem_stage_alpha.sv
// Memory-access stage of the alpha pipeline: turns ALU results into bus
// load/store transactions and produces one registered writeback record per instruction.
module mem_stage_alpha (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        ex_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] ex_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  ex_waddr,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        exp_adel,
    output logic        exp_ades,
    output logic [31:0] badvaddr,
    output logic        stall_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    function automatic logic is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            OP_LW, OP_SW:         return 2'd2;
            default:              return 2'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd1:    return off[0];
            2'd2:    return off != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   return 4'b0001 << off;
            OP_SH:   return 4'b0011 << off;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [4:0]  waddr_q, waddr_d;
    logic        done_q, done_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_waddr_q, wb_waddr_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic        adel_q, adel_d;
    logic        ades_q, ades_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        stall_s;
    logic        finish_s;

    // Next-state, transaction latch and writeback-record logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_d       = wr_q;
        size_d     = size_q;
        waddr_d    = waddr_q;
        done_d     = 1'b0;
        wb_valid_d = 1'b0;
        wb_waddr_d = 5'd0;
        wb_wdata_d = 32'd0;
        adel_d     = 1'b0;
        ades_d     = 1'b0;
        badvaddr_d = 32'd0;
        stall_s    = 1'b0;
        finish_s   = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q marks the cycle the stalled instruction retires; it is still on the inputs.
                if (!flush_i && ex_valid && !done_q) begin
                    if (!is_mem(mem_op)) begin
                        wb_valid_d = 1'b1;
                        wb_wdata_d = ex_result;
                        wb_waddr_d = ex_waddr;
                    end else if (misaligned(op_size(mem_op), ex_result[1:0])) begin
                        wb_valid_d = 1'b1;
                        adel_d     = !is_store(mem_op);
                        ades_d     = is_store(mem_op);
                        badvaddr_d = ex_result;
                    end else begin
                        op_d    = mem_op;
                        addr_d  = ex_result;
                        wdata_d = store_lanes(mem_op, store_data);
                        wstrb_d = store_strb(mem_op, ex_result[1:0]);
                        wr_d    = is_store(mem_op);
                        size_d  = op_size(mem_op);
                        waddr_d = ex_waddr;
                        stall_s = 1'b1;
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                stall_s = !flush_i;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (data_addr_ok) begin
                    finish_s = data_data_ok;
                    state_d  = data_data_ok ? IDLE : WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                stall_s = !flush_i;
                if (flush_i) begin
                    state_d = data_data_ok ? IDLE : DRAIN;
                end else if (data_data_ok) begin
                    finish_s = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                stall_s = !flush_i && ex_valid && is_mem(mem_op);
                if (data_data_ok) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish_s) begin
            done_d     = 1'b1;
            wb_valid_d = 1'b1;
            wb_waddr_d = wr_q ? 5'd0 : waddr_q;
            wb_wdata_d = wr_q ? 32'd0 : load_ext(op_q, addr_q[1:0], data_rdata);
        end else begin
            done_d = 1'b0;
        end
    end

    // State, latched transaction and registered writeback record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            waddr_q    <= 5'd0;
            done_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_waddr_q <= 5'd0;
            wb_wdata_q <= 32'd0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            badvaddr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            waddr_q    <= waddr_d;
            done_q     <= done_d;
            wb_valid_q <= wb_valid_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            adel_q     <= adel_d;
            ades_q     <= ades_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // A flush must withdraw the request within the same cycle, so req and stall stay combinational.
    assign data_req   = (state_q == REQ) && !flush_i && !rst;
    assign stall_o    = stall_s && !rst;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign data_wstrb = wstrb_q;
    assign wb_valid   = wb_valid_q;
    assign wb_waddr   = wb_waddr_q;
    assign wb_wdata   = wb_wdata_q;
    assign exp_adel   = adel_q;
    assign exp_ades   = ades_q;
    assign badvaddr   = badvaddr_q;

endmodule

// File: tb/tb_mem_stage_alpha.sv
// Directed bench for mem_stage_alpha: each task drives one scenario and checks
// hand-computed expectations two time units after the active clock edge.
module tb_mem_stage_alpha;

    logic        clk, rst, flush_i, ex_valid;
    logic [3:0]  mem_op;
    logic [31:0] ex_result, store_data;
    logic [4:0]  ex_waddr;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        exp_adel, exp_ades;
    logic [31:0] badvaddr;
    logic        stall_o;

    int checks = 0;
    int failures = 0;

    mem_stage_alpha dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .ex_valid(ex_valid), .mem_op(mem_op),
        .ex_result(ex_result), .store_data(store_data), .ex_waddr(ex_waddr),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .wb_valid(wb_valid),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .exp_adel(exp_adel), .exp_ades(exp_ades),
        .badvaddr(badvaddr), .stall_o(stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] res,
                           input logic [31:0] sd, input logic [4:0] wa);
        ex_valid = 1'b1; mem_op = op; ex_result = res; store_data = sd; ex_waddr = wa;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        present(4'd5, 32'h0000_1000, 32'd0, 5'd1);
        tick(); tick(); #1;
        checks++; if ({data_req, data_wr, data_size, data_wstrb, stall_o} !== 9'd0) begin
            failures++; $display("FAIL reset_bus_ctrl got=%b exp=0", {data_req, data_wr, data_size, data_wstrb, stall_o}); end
        checks++; if ({wb_valid, wb_waddr, exp_adel, exp_ades} !== 8'd0) begin
            failures++; $display("FAIL reset_wb_ctrl got=%b exp=0", {wb_valid, wb_waddr, exp_adel, exp_ades}); end
        checks++; if ({data_addr, data_wdata, wb_wdata, badvaddr} !== 128'd0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {data_addr, data_wdata, wb_wdata, badvaddr}); end
        ex_valid = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_none();
        present(4'd0, 32'h1234_5678, 32'd0, 5'd3); #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL none_stall got=%b exp=0", stall_o); end
        tick();
        present(4'd12, 32'hA5A5_0001, 32'd0, 5'd4); #1;
        checks++; if ({wb_valid, wb_waddr, wb_wdata} !== {1'b1, 5'd3, 32'h1234_5678}) begin
            failures++; $display("FAIL none_wb got=%h exp=%h", {wb_valid, wb_waddr, wb_wdata}, {1'b1, 5'd3, 32'h1234_5678}); end
        checks++; if ({data_req, stall_o} !== 2'b00) begin
            failures++; $display("FAIL none_nobus got=%b exp=00", {data_req, stall_o}); end
        tick();
        ex_valid = 1'b0; data_data_ok = 1'b1; #1;
        checks++; if ({wb_valid, wb_waddr, wb_wdata} !== {1'b1, 5'd4, 32'hA5A5_0001}) begin
            failures++; $display("FAIL none_b2b_wb got=%h exp=%h", {wb_valid, wb_waddr, wb_wdata}, {1'b1, 5'd4, 32'hA5A5_0001}); end
        tick();
        data_data_ok = 1'b0;
        present(4'd0, 32'h0000_0077, 32'd0, 5'd5); flush_i = 1'b1; #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL idle_dataok_ignored got=%b exp=0", wb_valid); end
        tick();
        ex_valid = 1'b0; flush_i = 1'b0; #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL none_flushed got=%b exp=0", wb_valid); end
        tick();
    endtask

    task automatic test_load(input string name, input logic [3:0] op, input logic [31:0] expv);
        present(op, 32'h0000_1003, 32'd0, 5'd6); #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL %s_accept_stall got=%b exp=1", name, stall_o); end
        tick();
        data_addr_ok = 1'b1; #1;
        checks++; if ({data_req, data_wr, data_size, data_wstrb, data_addr} !== {1'b1, 1'b0, 2'd0, 4'd0, 32'h0000_1003}) begin
            failures++; $display("FAIL %s_req got=%h exp=%h", name, {data_req, data_wr, data_size, data_wstrb, data_addr},
                                 {1'b1, 1'b0, 2'd0, 4'd0, 32'h0000_1003}); end
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h8012_3456; #1;
        checks++; if ({data_req, stall_o, wb_valid} !== 3'b010) begin
            failures++; $display("FAIL %s_wait got=%b exp=010", name, {data_req, stall_o, wb_valid}); end
        tick();
        data_data_ok = 1'b0; #1;
        checks++; if ({wb_valid, wb_waddr, wb_wdata, stall_o} !== {1'b1, 5'd6, expv, 1'b0}) begin
            failures++; $display("FAIL %s_wb got=%h exp=%h", name, {wb_valid, wb_waddr, wb_wdata, stall_o}, {1'b1, 5'd6, expv, 1'b0}); end
        tick();
        ex_valid = 1'b0; #1;
        checks++; if ({wb_valid, data_req} !== 2'b00) begin
            failures++; $display("FAIL %s_retired got=%b exp=00", name, {wb_valid, data_req}); end
        tick();
    endtask

    task automatic test_store_sh();
        present(4'd7, 32'h0000_2002, 32'h0000_BEEF, 5'd8); tick();
        ex_valid = 1'b0; data_addr_ok = 1'b1; #1;
        checks++; if ({data_req, data_wr, data_size, data_wstrb, data_wdata} !== {1'b1, 1'b1, 2'd1, 4'b1100, 32'hBEEF_BEEF}) begin
            failures++; $display("FAIL sh_req got=%h exp=%h", {data_req, data_wr, data_size, data_wstrb, data_wdata},
                                 {1'b1, 1'b1, 2'd1, 4'b1100, 32'hBEEF_BEEF}); end
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; tick();
        data_data_ok = 1'b0; #1;
        checks++; if ({wb_valid, wb_waddr} !== {1'b1, 5'd0}) begin
            failures++; $display("FAIL sh_wb got=%h exp=%h", {wb_valid, wb_waddr}, {1'b1, 5'd0}); end
        tick();
    endtask

    task automatic test_sb_same_cycle();
        present(4'd6, 32'h0000_2001, 32'h1234_56A5, 5'd8); tick();
        ex_valid = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; #1;
        checks++; if ({data_req, data_size, data_wstrb, data_wdata} !== {1'b1, 2'd0, 4'b0010, 32'hA5A5_A5A5}) begin
            failures++; $display("FAIL sb_req got=%h exp=%h", {data_req, data_size, data_wstrb, data_wdata},
                                 {1'b1, 2'd0, 4'b0010, 32'hA5A5_A5A5}); end
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
        checks++; if ({wb_valid, wb_waddr, data_req} !== {1'b1, 5'd0, 1'b0}) begin
            failures++; $display("FAIL sb_skip_wait_wb got=%b exp=%b", {wb_valid, wb_waddr, data_req}, {1'b1, 5'd0, 1'b0}); end
        tick();
    endtask

    task automatic test_misaligned();
        present(4'd5, 32'h0000_3001, 32'd0, 5'd11); #1;
        checks++; if ({stall_o, data_req} !== 2'b00) begin
            failures++; $display("FAIL lw_mis_nostall got=%b exp=00", {stall_o, data_req}); end
        tick();
        present(4'd8, 32'h0000_3002, 32'd0, 5'd12); #1;
        checks++; if ({wb_valid, exp_adel, exp_ades, wb_waddr, badvaddr, data_req} !== {3'b110, 5'd0, 32'h0000_3001, 1'b0}) begin
            failures++; $display("FAIL lw_adel got=%h exp=%h", {wb_valid, exp_adel, exp_ades, wb_waddr, badvaddr, data_req},
                                 {3'b110, 5'd0, 32'h0000_3001, 1'b0}); end
        tick();
        present(4'd3, 32'h0000_3003, 32'd0, 5'd13); #1;
        checks++; if ({wb_valid, exp_adel, exp_ades, badvaddr} !== {3'b101, 32'h0000_3002}) begin
            failures++; $display("FAIL sw_ades got=%h exp=%h", {wb_valid, exp_adel, exp_ades, badvaddr}, {3'b101, 32'h0000_3002}); end
        tick();
        ex_valid = 1'b0; #1;
        checks++; if ({exp_adel, exp_ades, badvaddr} !== {2'b10, 32'h0000_3003}) begin
            failures++; $display("FAIL lh_adel got=%h exp=%h", {exp_adel, exp_ades, badvaddr}, {2'b10, 32'h0000_3003}); end
        tick();
        checks++; if ({wb_valid, exp_adel, exp_ades} !== 3'b000) begin
            failures++; $display("FAIL exc_pulse_end got=%b exp=000", {wb_valid, exp_adel, exp_ades}); end
    endtask

    task automatic test_delayed_lw();
        int pulses;
        present(4'd5, 32'h0000_4000, 32'd0, 5'd7); tick();
        for (int c = 1; c <= 6; c++) begin
            data_addr_ok = (c == 4); data_data_ok = (c == 6); data_rdata = 32'h0BAD_F00D; #1;
            checks++; if ({stall_o, wb_valid} !== 2'b10) begin
                failures++; $display("FAIL dly_stall_c%0d got=%b exp=10", c, {stall_o, wb_valid}); end
            checks++; if ({data_req, data_addr} !== {(c <= 4), (c <= 4) ? 32'h0000_4000 : data_addr}) begin
                failures++; $display("FAIL dly_req_c%0d got=%h exp_req=%0d addr=00004000", c, {data_req, data_addr}, (c <= 4)); end
            tick();
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
        checks++; if ({wb_valid, wb_waddr, wb_wdata, stall_o} !== {1'b1, 5'd7, 32'h0BAD_F00D, 1'b0}) begin
            failures++; $display("FAIL dly_wb got=%h exp=%h", {wb_valid, wb_waddr, wb_wdata, stall_o}, {1'b1, 5'd7, 32'h0BAD_F00D, 1'b0}); end
        tick();
        ex_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            pulses += int'(wb_valid);
            tick();
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL dly_extra_wb got=%0d exp=0", pulses); end
    endtask

    task automatic test_flush_req();
        present(4'd5, 32'h0000_4100, 32'd0, 5'd2); tick();
        ex_valid = 1'b0; flush_i = 1'b1; #1;
        checks++; if ({data_req, stall_o} !== 2'b00) begin
            failures++; $display("FAIL flush_req_drop got=%b exp=00", {data_req, stall_o}); end
        tick();
        flush_i = 1'b0; #1;
        checks++; if ({data_req, wb_valid} !== 2'b00) begin
            failures++; $display("FAIL flush_req_idle got=%b exp=00", {data_req, wb_valid}); end
        tick();
    endtask

    task automatic test_flush_wait();
        present(4'd5, 32'h0000_5000, 32'd0, 5'd9); tick();
        data_addr_ok = 1'b1; tick();
        data_addr_ok = 1'b0; ex_valid = 1'b0; flush_i = 1'b1; #1;
        checks++; if ({stall_o, data_req} !== 2'b00) begin
            failures++; $display("FAIL flush_wait_stall got=%b exp=00", {stall_o, data_req}); end
        tick();
        flush_i = 1'b0; present(4'd5, 32'h0000_5004, 32'd0, 5'd10); #1;
        checks++; if ({stall_o, data_req, wb_valid} !== 3'b100) begin
            failures++; $display("FAIL drain_hold got=%b exp=100", {stall_o, data_req, wb_valid}); end
        tick();
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; #1;
        checks++; if ({stall_o, data_req} !== 2'b10) begin
            failures++; $display("FAIL drain_dataok got=%b exp=10", {stall_o, data_req}); end
        tick();
        data_data_ok = 1'b0; #1;
        checks++; if ({wb_valid, stall_o, data_req} !== 3'b010) begin
            failures++; $display("FAIL drain_discard got=%b exp=010", {wb_valid, stall_o, data_req}); end
        tick();
        data_addr_ok = 1'b1; #1;
        checks++; if ({data_req, data_addr} !== {1'b1, 32'h0000_5004}) begin
            failures++; $display("FAIL reissue_req got=%h exp=%h", {data_req, data_addr}, {1'b1, 32'h0000_5004}); end
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; tick();
        data_data_ok = 1'b0; #1;
        checks++; if ({wb_valid, wb_waddr, wb_wdata} !== {1'b1, 5'd10, 32'hCAFE_F00D}) begin
            failures++; $display("FAIL reissue_wb got=%h exp=%h", {wb_valid, wb_waddr, wb_wdata}, {1'b1, 5'd10, 32'hCAFE_F00D}); end
        tick();
        ex_valid = 1'b0; tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_none();
        test_load("lb", 4'd1, 32'hFFFF_FF80);
        test_load("lbu", 4'd2, 32'h0000_0080);
        test_store_sh();
        test_sb_same_cycle();
        test_misaligned();
        test_delayed_lw();
        test_flush_req();
        test_flush_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_alpha.md
# mem_stage_alpha

Memory-access stage of the alpha pipeline, directly downstream of the alpha ALU. It takes the ALU result as either an effective address or a pass-through value and performs load/store transactions on the data bus with a two-phase (address-ok / data-ok) handshake. It sign- or zero-extends load data, raises address-error exceptions, and presents one registered writeback record per instruction. It stalls the pipeline while a bus transaction is outstanding.

## Interface
Parameters: none.
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush; kills the in-flight instruction
- ex_valid  in  1  EX stage presents an instruction this cycle
- mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NONE
- ex_result  in  32  ALU result: effective address for memory ops, writeback value for NONE
- store_data  in  32  rt value for stores
- ex_waddr  in  5  destination register
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  byte address
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte enables
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  read data
- wb_valid  out  1  writeback record valid (1-cycle pulse)
- wb_waddr  out  5  destination register (0 for stores and exceptions)
- wb_wdata  out  32  writeback value
- exp_adel  out  1  load address error
- exp_ades  out  1  store address error
- badvaddr  out  32  faulting address
- stall_o  out  1  hold upstream stages

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE, ex_valid & NONE & !flush_i: next cycle wb_valid=1, wb_wdata=ex_result, wb_waddr=ex_waddr.
- IDLE, ex_valid & memory op & !flush_i:
  - Misalignment check: half with addr[0]=1; word with addr[1:0]≠0.
  - Misaligned: no bus access. Next cycle wb_valid=1, exp_adel (loads) or exp_ades (stores)=1, badvaddr=ex_result, wb_waddr=0.
  - Aligned: latch op, address, data and waddr; go to REQ.
- REQ: data_req=1 with stable fields; on data_addr_ok go to WAIT.
- WAIT: on data_data_ok, register the result, pulse wb_valid next cycle, go to IDLE.
- Store encoding:
  - SB: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=store_data, wstrb=4'b1111.
  - Loads drive wstrb=0.
- Load extraction: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- Stores: wb_valid pulses with wb_waddr=0.
- flush_i:
  - In IDLE or REQ: abandon the op with no wb_valid; data_req drops the same cycle; go to IDLE.
  - In WAIT: the address has already been accepted, so go to DRAIN. DRAIN discards data_data_ok, then returns to IDLE.
- While in DRAIN, a new memory op presented is held via stall_o and is not latched.

## Timing
- Reset: every output is 0; state=IDLE.
- stall_o:
  - =0 whenever flush_i=1.
  - Otherwise =1 in the IDLE cycle that accepts an aligned memory op, throughout REQ and WAIT, and in DRAIN if ex_valid presents a memory op.
  - =0 in the cycle wb_valid pulses.
- Zero-wait bus (addr_ok in the first REQ cycle, data_ok the next cycle): accept at cycle T, REQ at T+1, WAIT at T+2, wb_valid at T+3.
- Non-memory op and exception latency: 1 cycle, no stall.
- data_addr_ok and data_data_ok in the same REQ cycle: treat as complete and skip WAIT.
- data_data_ok in IDLE is ignored.
- Exactly one outstanding transaction at a time.

## Test plan
- NONE, ex_result=0x1234_5678, ex_waddr=3 -> next cycle wb_valid=1, wb_wdata=0x1234_5678, wb_waddr=3, stall_o=0.
- LB addr=0x1003, rdata=0x80xx_xxxx, zero-wait bus -> data_size=0; wb_wdata=0xFFFF_FF80 three cycles later. LBU on the same data -> 0x0000_0080.
- SH addr=0x2002, store_data=0x0000_BEEF -> data_wr=1, wdata=0xBEEF_BEEF, wstrb=4'b1100, size=1; wb_waddr=0.
- LW addr=0x3001 -> no data_req; next cycle exp_adel=1, badvaddr=0x3001. SW addr=0x3002 -> exp_ades=1.
- LW with data_addr_ok delayed 3 cycles and data_data_ok 2 cycles later -> data_req held with stable fields; stall_o=1 throughout; exactly one wb_valid.
- flush_i asserted in WAIT -> stall_o=0, no wb_valid. A following LW waits until the discarded data_data_ok arrives, then issues normally.
